// File: rtl/hdpldadapt_cmn_cp_bond_ctrl_if.sv
// Bonding-chain bundle interface: local master bundle, neighbour inputs,
// and the distributed outputs/taps of one bonding slice.
interface hdpldadapt_cmn_cp_bond_ctrl_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] master_in;
    logic [WIDTH-1:0] us_in;
    logic [WIDTH-1:0] ds_in;
    logic [WIDTH-1:0] us_out;
    logic [WIDTH-1:0] ds_out;
    logic [WIDTH-1:0] us_tap;
    logic [WIDTH-1:0] ds_tap;

    modport master (
        output master_in,
        output us_in,
        output ds_in,
        input  us_out,
        input  ds_out,
        input  us_tap,
        input  ds_tap
    );

    modport slave (
        input  master_in,
        input  us_in,
        input  ds_in,
        output us_out,
        output ds_out,
        output us_tap,
        output ds_tap
    );
endinterface

// File: rtl/hdpldadapt_cmn_cp_bond_ctrl.sv
// Channel-bonding control-plane slice: distributes the control bundle along the
// bonding chain, aligns the local channel to the trigger and watches for loss of bond.
module hdpldadapt_cmn_cp_bond_ctrl #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned CNTWIDTH        = 8,
    parameter int unsigned LOSSWIDTH       = 4,
    parameter logic        ASYNC_RESET_VAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst_n,
    input  logic                 data_enable,
    input  logic                 r_us_master,
    input  logic                 r_ds_master,
    input  logic                 r_us_bypass_pipeln,
    input  logic                 r_ds_bypass_pipeln,
    input  logic [1:0]           r_compin_sel,
    input  logic [CNTWIDTH-1:0]  r_comp_cnt,
    input  logic                 r_double_en,
    input  logic [LOSSWIDTH-1:0] r_loss_cnt,
    input  logic                 r_bonding_dft_in_en,
    input  logic                 r_bonding_dft_in_value,
    input  logic                 rearm,
    hdpldadapt_cmn_cp_bond_ctrl_if.slave bus,
    output logic                 compin_sel,
    output logic                 comp_out_en,
    output logic [1:0]           bond_state,
    output logic                 bond_lost,
    output logic [15:0]          testbus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_LOST  = 2'd3
    } state_e;

    localparam int unsigned CW = CNTWIDTH + 1;

    logic [WIDTH-1:0]     us_in_gated_s;
    logic [WIDTH-1:0]     ds_in_gated_s;
    logic [WIDTH-1:0]     us_src_s;
    logic [WIDTH-1:0]     ds_src_s;
    logic [WIDTH-1:0]     us_d;
    logic [WIDTH-1:0]     ds_d;
    logic [WIDTH-1:0]     us_q;
    logic [WIDTH-1:0]     ds_q;
    logic                 trig_s;
    logic                 loss_hit_s;
    logic [CW-1:0]        tgt_s;
    logic [CW-1:0]        cnt_q;
    logic [LOSSWIDTH-1:0] lcnt_q;
    logic [7:0]           cnt_dbg_s;
    state_e               state_q;
    logic                 bond_lost_q;
    logic                 comp_out_en_q;

    // Neighbour scan gating and stream source selection
    always_comb begin
        us_in_gated_s = bus.us_in;
        ds_in_gated_s = bus.ds_in;
        if (r_bonding_dft_in_en) begin
            us_in_gated_s = {WIDTH{r_bonding_dft_in_value}};
            ds_in_gated_s = {WIDTH{r_bonding_dft_in_value}};
        end else begin
            us_in_gated_s = bus.us_in;
            ds_in_gated_s = bus.ds_in;
        end
        if (r_us_master) begin
            us_src_s = bus.master_in;
        end else begin
            us_src_s = ds_in_gated_s;
        end
        if (r_ds_master) begin
            ds_src_s = bus.master_in;
        end else begin
            ds_src_s = us_in_gated_s;
        end
        us_d = us_src_s;
        ds_d = ds_src_s;
    end

    // Trigger selection, compensation target and loss-threshold detect
    always_comb begin
        trig_s     = 1'b0;
        tgt_s      = {1'b0, r_comp_cnt};
        loss_hit_s = 1'b0;
        case (r_compin_sel)
            2'd0:    trig_s = bus.master_in[0];
            2'd1:    trig_s = us_src_s[0];
            2'd2:    trig_s = ds_src_s[0];
            default: trig_s = 1'b0;
        endcase
        if (r_double_en) begin
            tgt_s = {r_comp_cnt, 1'b0};
        end else begin
            tgt_s = {1'b0, r_comp_cnt};
        end
        // A threshold of zero turns loss detection off entirely
        if ((r_loss_cnt != {LOSSWIDTH{1'b0}}) && !trig_s &&
            (lcnt_q == (r_loss_cnt - LOSSWIDTH'(1)))) begin
            loss_hit_s = 1'b1;
        end else begin
            loss_hit_s = 1'b0;
        end
    end

    // Per-direction pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_q <= {WIDTH{ASYNC_RESET_VAL}};
            ds_q <= {WIDTH{ASYNC_RESET_VAL}};
        end else if (!srst_n) begin
            us_q <= {WIDTH{ASYNC_RESET_VAL}};
            ds_q <= {WIDTH{ASYNC_RESET_VAL}};
        end else if (data_enable) begin
            us_q <= us_d;
            ds_q <= ds_d;
        end else begin
            us_q <= us_q;
            ds_q <= ds_q;
        end
    end

    // Compensation / loss-of-bond FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CW{1'b0}};
            lcnt_q        <= {LOSSWIDTH{1'b0}};
            bond_lost_q   <= 1'b0;
            comp_out_en_q <= 1'b0;
        end else if (!srst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CW{1'b0}};
            lcnt_q        <= {LOSSWIDTH{1'b0}};
            bond_lost_q   <= 1'b0;
            comp_out_en_q <= 1'b0;
        end else if (data_enable) begin
            if (rearm) begin
                state_q       <= ST_IDLE;
                cnt_q         <= {CW{1'b0}};
                lcnt_q        <= {LOSSWIDTH{1'b0}};
                bond_lost_q   <= 1'b0;
                comp_out_en_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= {CW{1'b0}};
                        if (trig_s) begin
                            if (tgt_s == {CW{1'b0}}) begin
                                state_q       <= ST_DONE;
                                comp_out_en_q <= 1'b1;
                            end else begin
                                state_q <= ST_COUNT;
                                cnt_q   <= CW'(1);
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (cnt_q == tgt_s) begin
                            state_q       <= ST_DONE;
                            comp_out_en_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (trig_s) begin
                            lcnt_q <= {LOSSWIDTH{1'b0}};
                        end else begin
                            lcnt_q <= lcnt_q + LOSSWIDTH'(1);
                        end
                        if (loss_hit_s) begin
                            state_q       <= ST_LOST;
                            bond_lost_q   <= 1'b1;
                            comp_out_en_q <= 1'b0;
                        end
                    end
                    ST_LOST: begin
                        state_q <= ST_LOST;
                    end
                    default: begin
                        state_q       <= ST_IDLE;
                        comp_out_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    generate
        if (CW >= 8) begin : g_dbg_trunc
            assign cnt_dbg_s = cnt_q[7:0];
        end else begin : g_dbg_ext
            assign cnt_dbg_s = {{(8 - CW){1'b0}}, cnt_q};
        end
    endgenerate

    assign bus.us_tap  = us_src_s;
    assign bus.ds_tap  = ds_src_s;
    assign bus.us_out  = r_us_bypass_pipeln ? us_src_s : us_q;
    assign bus.ds_out  = r_ds_bypass_pipeln ? ds_src_s : ds_q;
    assign compin_sel  = trig_s;
    assign comp_out_en = comp_out_en_q;
    assign bond_state  = state_q;
    assign bond_lost   = bond_lost_q;
    assign testbus     = {state_q, bond_lost_q, comp_out_en_q, trig_s, bus.master_in[0],
                          us_src_s[0], ds_src_s[0], cnt_dbg_s};
endmodule

// File: tb/tb_hdpldadapt_cmn_cp_bond_ctrl.sv
// Bench for the bonding control slice: an edge-counting reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hdpldadapt_cmn_cp_bond_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, srst_n, data_enable;
    logic       r_us_master, r_ds_master, r_us_bypass_pipeln, r_ds_bypass_pipeln;
    logic [1:0] r_compin_sel;
    logic [7:0] r_comp_cnt;
    logic       r_double_en;
    logic [3:0] r_loss_cnt;
    logic       r_bonding_dft_in_en, r_bonding_dft_in_value, rearm;
    logic       compin_sel, comp_out_en, bond_lost;
    logic [1:0] bond_state;
    logic [15:0] testbus;

    int n_pass  = 0;
    int n_total = 0;

    hdpldadapt_cmn_cp_bond_ctrl_if #(.WIDTH(4)) bus ();

    hdpldadapt_cmn_cp_bond_ctrl #(
        .WIDTH(4), .CNTWIDTH(8), .LOSSWIDTH(4), .ASYNC_RESET_VAL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .srst_n(srst_n), .data_enable(data_enable),
        .r_us_master(r_us_master), .r_ds_master(r_ds_master),
        .r_us_bypass_pipeln(r_us_bypass_pipeln), .r_ds_bypass_pipeln(r_ds_bypass_pipeln),
        .r_compin_sel(r_compin_sel), .r_comp_cnt(r_comp_cnt), .r_double_en(r_double_en),
        .r_loss_cnt(r_loss_cnt), .r_bonding_dft_in_en(r_bonding_dft_in_en),
        .r_bonding_dft_in_value(r_bonding_dft_in_value), .rearm(rearm),
        .bus(bus), .compin_sel(compin_sel), .comp_out_en(comp_out_en),
        .bond_state(bond_state), .bond_lost(bond_lost), .testbus(testbus)
    );

    always #5 clk = ~clk;

    // Reference model: mode follows the bond_state numbering, timing kept as edge indices
    int          m_mode      = 0;
    int          m_edge      = 0;
    int          m_trig_edge = 0;
    int          m_hold_cnt  = 0;
    int          m_lows      = 0;
    logic        m_lost      = 1'b0;
    logic [3:0]  m_us_q      = 4'hF;
    logic [3:0]  m_ds_q      = 4'hF;

    function automatic logic [3:0] us_src_f();
        logic [3:0] g;
        g = r_bonding_dft_in_en ? {4{r_bonding_dft_in_value}} : bus.ds_in;
        return r_us_master ? bus.master_in : g;
    endfunction

    function automatic logic [3:0] ds_src_f();
        logic [3:0] g;
        g = r_bonding_dft_in_en ? {4{r_bonding_dft_in_value}} : bus.us_in;
        return r_ds_master ? bus.master_in : g;
    endfunction

    function automatic logic trig_f();
        logic [3:0] u, d;
        u = us_src_f();
        d = ds_src_f();
        if (r_compin_sel == 2'd0) return bus.master_in[0];
        else if (r_compin_sel == 2'd1) return u[0];
        else if (r_compin_sel == 2'd2) return d[0];
        else return 1'b0;
    endfunction

    function automatic int tgt_f();
        return r_double_en ? 2 * int'(r_comp_cnt) : int'(r_comp_cnt);
    endfunction

    function automatic logic [15:0] exp_tb_f();
        logic [3:0] u, d;
        int c;
        u = us_src_f();
        d = ds_src_f();
        if (m_mode == 1) c = m_edge - m_trig_edge;
        else if (m_mode == 0) c = 0;
        else c = m_hold_cnt;
        return {2'(m_mode), m_lost, 1'(m_mode == 2), trig_f(), bus.master_in[0], u[0], d[0], 8'(c)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !srst_n) begin
            m_mode <= 0; m_lows <= 0; m_lost <= 1'b0;
            m_us_q <= 4'hF; m_ds_q <= 4'hF;
        end else if (data_enable) begin
            m_us_q <= us_src_f();
            m_ds_q <= ds_src_f();
            m_edge <= m_edge + 1;
            if (rearm) begin
                m_mode <= 0; m_lows <= 0; m_lost <= 1'b0;
            end else if (m_mode == 0 && trig_f()) begin
                m_trig_edge <= m_edge;
                m_hold_cnt  <= 0;
                m_mode      <= (tgt_f() == 0) ? 2 : 1;
            end else if (m_mode == 1 && m_edge == m_trig_edge + tgt_f()) begin
                m_mode     <= 2;
                m_hold_cnt <= tgt_f();
            end else if (m_mode == 2) begin
                m_lows <= trig_f() ? 0 : m_lows + 1;
                if (!trig_f() && r_loss_cnt != 4'd0 && m_lows + 1 == int'(r_loss_cnt)) begin
                    m_mode <= 3;
                    m_lost <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("us_tap", 16'(bus.us_tap), 16'(us_src_f()));
        chk("ds_tap", 16'(bus.ds_tap), 16'(ds_src_f()));
        chk("us_out", 16'(bus.us_out), 16'(r_us_bypass_pipeln ? us_src_f() : m_us_q));
        chk("ds_out", 16'(bus.ds_out), 16'(r_ds_bypass_pipeln ? ds_src_f() : m_ds_q));
        chk("compin_sel", 16'(compin_sel), 16'(trig_f()));
        chk("bond_state", 16'(bond_state), 16'(m_mode));
        chk("comp_out_en", 16'(comp_out_en), 16'(m_mode == 2));
        chk("bond_lost", 16'(bond_lost), 16'(m_lost));
        chk("testbus", testbus, exp_tb_f());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Rearm, raise the trigger after an edge, then count edges until comp_out_en
    task automatic run_latency(input string name, input logic [7:0] cnt, input logic dbl,
                               input int exp, input int hold_at);
        int k;
        int got;
        r_comp_cnt = cnt; r_double_en = dbl;
        bus.master_in = 4'h0; rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
        tick(1);
        bus.master_in = 4'h1;
        k = 0; got = -1;
        while (k < 700 && got < 0) begin
            @(posedge clk); #1;
            k++;
            if (comp_out_en) got = k;
            else if (hold_at > 0 && k == hold_at) data_enable = 1'b0;
            else if (hold_at > 0 && k == hold_at + 4) data_enable = 1'b1;
            if (hold_at > 0 && k == hold_at + 3) chk("hold_usq", 16'(bus.us_out), 16'h0003);
            bus.master_in[3:1] = k[2:0];
            #1;
        end
        chk(name, 16'(got), 16'(exp));
    endtask

    initial begin
        rst_n = 1'b0; srst_n = 1'b1; data_enable = 1'b1;
        r_us_master = 1'b1; r_ds_master = 1'b1;
        r_us_bypass_pipeln = 1'b0; r_ds_bypass_pipeln = 1'b0;
        r_compin_sel = 2'd0; r_comp_cnt = 8'd5; r_double_en = 1'b0; r_loss_cnt = 4'd0;
        r_bonding_dft_in_en = 1'b0; r_bonding_dft_in_value = 1'b0; rearm = 1'b0;
        bus.master_in = 4'h0; bus.us_in = 4'h0; bus.ds_in = 4'h0;

        tick(3);
        chk("rst_us_out", 16'(bus.us_out), 16'h000F);
        chk("rst_ds_out", 16'(bus.ds_out), 16'h000F);
        chk("rst_state", 16'(bond_state), 16'h0000);
        chk("rst_comp_en", 16'(comp_out_en), 16'h0000);
        chk("rst_testbus", testbus, 16'h0000);
        rst_n = 1'b1;
        tick(1);

        // Distribution and pipeline bypass
        bus.master_in = 4'hA; #1;
        chk("us_out_reg_lat", 16'(bus.us_out), 16'h0000);
        tick(1);
        chk("us_out_reg", 16'(bus.us_out), 16'h000A);
        r_us_bypass_pipeln = 1'b1; bus.master_in = 4'h4; #1;
        chk("us_out_bypass", 16'(bus.us_out), 16'h0004);
        r_ds_master = 1'b0; r_bonding_dft_in_en = 1'b1; r_bonding_dft_in_value = 1'b0;
        bus.us_in = 4'hF; r_ds_bypass_pipeln = 1'b1; #1;
        chk("ds_out_dft0", 16'(bus.ds_out), 16'h0000);
        r_ds_bypass_pipeln = 1'b0;
        tick(1);
        chk("ds_out_dft0_reg", 16'(bus.ds_out), 16'h0000);
        r_bonding_dft_in_value = 1'b1;
        tick(1);
        chk("ds_out_dft1_reg", 16'(bus.ds_out), 16'h000F);
        r_bonding_dft_in_en = 1'b0; bus.us_in = 4'h6;
        tick(1);
        chk("ds_out_us_in", 16'(bus.ds_out), 16'h0006);
        r_us_master = 1'b0; bus.ds_in = 4'h3; r_compin_sel = 2'd1; #1;
        chk("sel_us_tap", 16'(compin_sel), 16'h0001);
        r_compin_sel = 2'd2; #1;
        chk("sel_ds_tap", 16'(compin_sel), 16'h0000);
        r_compin_sel = 2'd0; r_us_master = 1'b1; r_us_bypass_pipeln = 1'b0;
        bus.master_in = 4'h0;
        tick(1);

        // Compensation latency
        run_latency("lat_5", 8'd5, 1'b0, 6, 0);
        run_latency("lat_5_double", 8'd5, 1'b1, 11, 0);
        run_latency("lat_ff_double", 8'hFF, 1'b1, 511, 0);
        run_latency("lat_5_hold4", 8'd5, 1'b0, 10, 2);

        // Synchronous reset mid-count
        r_comp_cnt = 8'd5; r_double_en = 1'b0;
        bus.master_in = 4'h0; rearm = 1'b1; tick(1);
        rearm = 1'b0; bus.master_in = 4'h1; tick(2);
        chk("count_state", 16'(bond_state), 16'h0001);
        srst_n = 1'b0; tick(1);
        chk("srst_state", 16'(bond_state), 16'h0000);
        chk("srst_us_out", 16'(bus.us_out), 16'h000F);
        srst_n = 1'b1; bus.master_in = 4'h0; tick(1);

        // Loss detection
        run_latency("lat_0", 8'd0, 1'b0, 1, 0);
        r_loss_cnt = 4'd3; bus.master_in = 4'h0; tick(2);
        bus.master_in = 4'h1; tick(1);
        chk("loss_2low", 16'(bond_state), 16'h0002);
        bus.master_in = 4'h0; tick(2);
        chk("loss_before3", 16'(bond_state), 16'h0002);
        tick(1);
        chk("loss_state", 16'(bond_state), 16'h0003);
        chk("loss_flag", 16'(bond_lost), 16'h0001);
        chk("loss_comp_en", 16'(comp_out_en), 16'h0000);
        rearm = 1'b1; tick(1);
        chk("rearm_state", 16'(bond_state), 16'h0000);
        chk("rearm_lost", 16'(bond_lost), 16'h0000);
        rearm = 1'b0; bus.master_in = 4'h1; tick(1);
        r_loss_cnt = 4'd0; bus.master_in = 4'h0; tick(100);
        chk("loss_disabled", 16'(bond_state), 16'h0002);

        // Rearm and srst together: srst also reloads the pipeline register
        bus.master_in = 4'h6; rearm = 1'b1; srst_n = 1'b0; tick(1);
        chk("rearm_srst_state", 16'(bond_state), 16'h0000);
        chk("rearm_srst_us_out", 16'(bus.us_out), 16'h000F);
        rearm = 1'b0; srst_n = 1'b1;

        // No trigger source selected
        r_compin_sel = 2'd3;
        for (int k = 0; k < 20; k++) begin
            bus.master_in = 4'(k); bus.us_in = 4'(~k); bus.ds_in = 4'(k * 3);
            r_us_master = k[0]; r_ds_master = k[1];
            tick(1);
        end
        chk("sel3_state", 16'(bond_state), 16'h0000);
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
